knn_topk: RTL and testbench

Streaming k-nearest-neighbour engine and parametrised successor of the single-cycle squared-distance core. It computes the distance from one latched 2-D test point to a stream of labelled 2-D data points, one point per cycle. It keeps a sorted list of the K closest points with their labels. It sits between the peripheral register bank, which loads the test point and streams data points, and the classification logic, which reads the K results through an indexed read port.

---
 rtl/knn_topk_if.sv | 56 +++++
 rtl/knn_topk.sv | 241 ++++++++++++++++++++++++
 tb/tb_knn_topk.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/knn_topk_if.sv
`default_nettype none
// ============================================================================
//  Module      : knn_topk_if
//  Description : Bus bundle for the streaming k-nearest-neighbour engine.
//                It carries three groups of signals:
//                  - control and test point: start, test_x, test_y
//                  - data point stream: in_valid, in_x, in_y, in_label,
//                    in_last
//                  - result read port and status: rd_sel, rd_dist,
//                    rd_label, rd_valid, count, done
//                The master modport is the register-bank side, which loads
//                the test point, streams points and reads results. The slave
//                modport is the engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface knn_topk_if #(
    parameter int DATA_W  = 16,
    parameter int K       = 4,
    parameter int LABEL_W = 8
);
    localparam int DIST_W  = 2*DATA_W + 2;
    localparam int c_SEL_W = (K > 1) ? $clog2(K) : 1;
    localparam int c_CNT_W = $clog2(K + 1);

    logic                 start;
    logic [DATA_W-1:0]    test_x;
    logic [DATA_W-1:0]    test_y;

    logic                 in_valid;
    logic [DATA_W-1:0]    in_x;
    logic [DATA_W-1:0]    in_y;
    logic [LABEL_W-1:0]   in_label;
    logic                 in_last;

    logic [c_SEL_W-1:0]   rd_sel;
    logic [DIST_W-1:0]    rd_dist;
    logic [LABEL_W-1:0]   rd_label;
    logic                 rd_valid;
    logic [c_CNT_W-1:0]   count;
    logic                 done;

    modport master (
        output start, test_x, test_y,
        output in_valid, in_x, in_y, in_label, in_last,
        output rd_sel,
        input  rd_dist, rd_label, rd_valid, count, done
    );

    modport slave (
        input  start, test_x, test_y,
        input  in_valid, in_x, in_y, in_label, in_last,
        input  rd_sel,
        output rd_dist, rd_label, rd_valid, count, done
    );
endinterface
`default_nettype wire

// File: rtl/knn_topk.sv
`default_nettype none
// ============================================================================
//  Module      : knn_topk
//  Description : Streaming k-nearest-neighbour engine. It measures the
//                distance from a latched 2-D test point to one labelled data
//                point per clock, and keeps the K closest points sorted
//                ascending by distance.
//
//                Pipeline:
//                  S1     - coordinate differences
//                  S2     - distance
//                  insert - sorted list update
//
//                Optional build macro:
//                  KNN_L1_EN - Manhattan distance |dx|+|dy|
//                              (default: squared Euclidean dx^2+dy^2)
//
//                Ports:
//                  clk, rst : clock and asynchronous active-high reset
//                  bus      : knn_topk_if.slave
//                    - start/test_x/test_y : latch test point, clear list
//                    - in_*                : point stream, no backpressure
//                    - rd_sel -> rd_dist/rd_label/rd_valid : read port
//                    - count                : populated entries
//                    - done                 : batch completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module knn_topk #(
    parameter int DATA_W  = 16,
    parameter int K       = 4,
    parameter int LABEL_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    knn_topk_if.slave   bus
);
    localparam int DIST_W  = 2*DATA_W + 2;
    localparam int c_SEL_W = (K > 1) ? $clog2(K) : 1;
    localparam int c_CNT_W = $clog2(K + 1);
    localparam logic [DIST_W-1:0] c_DIST_EMPTY = '1;

    // ------------------------------------------------------------------
    // Test point and stage 1: differences, one bit wider than the inputs
    // so that the full signed range never wraps.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      r_tx;
    logic [DATA_W-1:0]      r_ty;
    logic signed [DATA_W:0] w_dx;
    logic signed [DATA_W:0] w_dy;

    assign w_dx = $signed({bus.in_x[DATA_W-1], bus.in_x}) - $signed({r_tx[DATA_W-1], r_tx});
    assign w_dy = $signed({bus.in_y[DATA_W-1], bus.in_y}) - $signed({r_ty[DATA_W-1], r_ty});

    logic                   r_s1_valid;
    logic                   r_s1_last;
    logic signed [DATA_W:0] r_s1_dx;
    logic signed [DATA_W:0] r_s1_dy;
    logic [LABEL_W-1:0]     r_s1_label;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx       <= '0;
            r_ty       <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_dx    <= '0;
            r_s1_dy    <= '0;
            r_s1_label <= '0;
        end else begin
            // A point arriving together with start belongs to neither batch.
            r_s1_valid <= bus.in_valid & ~bus.start;
            r_s1_last  <= bus.in_valid & bus.in_last & ~bus.start;
            if (bus.in_valid) begin
                r_s1_dx    <= w_dx;
                r_s1_dy    <= w_dy;
                r_s1_label <= bus.in_label;
            end
            if (bus.start) begin
                r_tx <= bus.test_x;
                r_ty <= bus.test_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: distance. Both metrics fit DIST_W exactly at the extremes.
    // ------------------------------------------------------------------
    logic [DIST_W-1:0] w_dist;

`ifdef KNN_L1_EN
    logic [DATA_W:0]   w_abs_dx;
    logic [DATA_W:0]   w_abs_dy;
    logic [DATA_W+1:0] w_l1_sum;

    // Negating -2^DATA_W gives the same bit pattern. Read as unsigned, that
    // pattern is the correct magnitude.
    assign w_abs_dx = r_s1_dx[DATA_W] ? $unsigned(-r_s1_dx) : $unsigned(r_s1_dx);
    assign w_abs_dy = r_s1_dy[DATA_W] ? $unsigned(-r_s1_dy) : $unsigned(r_s1_dy);
    assign w_l1_sum = {1'b0, w_abs_dx} + {1'b0, w_abs_dy};
    assign w_dist   = {{(DIST_W-DATA_W-2){1'b0}}, w_l1_sum};
`else
    logic [DIST_W-1:0] w_dx_ext;
    logic [DIST_W-1:0] w_dy_ext;

    // Sign-extended operands multiplied modulo 2^DIST_W give the exact
    // square, because the true result is known to fit.
    assign w_dx_ext = {{(DIST_W-DATA_W-1){r_s1_dx[DATA_W]}}, r_s1_dx};
    assign w_dy_ext = {{(DIST_W-DATA_W-1){r_s1_dy[DATA_W]}}, r_s1_dy};
    assign w_dist   = (w_dx_ext * w_dx_ext) + (w_dy_ext * w_dy_ext);
`endif

    logic               r_s2_valid;
    logic               r_s2_last;
    logic [DIST_W-1:0]  r_s2_dist;
    logic [LABEL_W-1:0] r_s2_label;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_dist  <= '0;
            r_s2_label <= '0;
        end else begin
            r_s2_valid <= r_s1_valid & ~bus.start;
            r_s2_last  <= r_s1_valid & r_s1_last & ~bus.start;
            if (r_s1_valid) begin
                r_s2_dist  <= w_dist;
                r_s2_label <= r_s1_label;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: sorted insert. Valid entries always form a prefix.
    // w_le[i] marks entries that stay ahead of the new point; ties keep the
    // older entry ahead. The ones in w_le form a prefix, and the insert
    // position is the first zero.
    // ------------------------------------------------------------------
    logic [DIST_W-1:0]  r_dist  [K];
    logic [LABEL_W-1:0] r_label [K];
    logic [K-1:0]       r_valid;
    logic [c_CNT_W-1:0] r_count;

    logic [K-1:0]       w_le;
    logic [K-1:0]       w_at_p;
    logic [DIST_W-1:0]  w_prev_dist  [K];
    logic [LABEL_W-1:0] w_prev_label [K];
    logic [K-1:0]       w_prev_valid;
    logic               w_insert;

    for (genvar i = 0; i < K; i++) begin : g_list
        assign w_le[i] = r_valid[i] && (r_dist[i] <= r_s2_dist);
        if (i == 0) begin : g_head
            assign w_at_p[i]       = ~w_le[i];
            assign w_prev_dist[i]  = c_DIST_EMPTY;
            assign w_prev_label[i] = '0;
            assign w_prev_valid[i] = 1'b0;
        end else begin : g_tail
            assign w_at_p[i]       = ~w_le[i] & w_le[i-1];
            assign w_prev_dist[i]  = r_dist[i-1];
            assign w_prev_label[i] = r_label[i-1];
            assign w_prev_valid[i] = r_valid[i-1];
        end
    end

    // If every entry is valid and no farther than the new point, then p = K
    // and the point is dropped.
    assign w_insert = r_s2_valid & ~w_le[K-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i]  <= c_DIST_EMPTY;
                r_label[i] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (bus.start) begin
            for (int i = 0; i < K; i++) begin
                r_dist[i]  <= c_DIST_EMPTY;
                r_label[i] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (w_insert) begin
            for (int i = 0; i < K; i++) begin
                if (w_at_p[i]) begin
                    r_dist[i]  <= r_s2_dist;
                    r_label[i] <= r_s2_label;
                    r_valid[i] <= 1'b1;
                end else if (!w_le[i]) begin
                    r_dist[i]  <= w_prev_dist[i];
                    r_label[i] <= w_prev_label[i];
                    r_valid[i] <= w_prev_valid[i];
                end
            end
            if (r_count != c_CNT_W'(K)) begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Batch completion. The marker trails the insert by one register, so
    // done rises the cycle after the list shows the final point.
    // ------------------------------------------------------------------
    logic r_s3_last;
    logic r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_last <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_s3_last <= r_s2_valid & r_s2_last & ~bus.start;
            r_done    <= r_s3_last;
        end
    end

    // ------------------------------------------------------------------
    // Read port. Unpopulated or out-of-range entries read as all zero, which
    // hides the all-ones empty-entry distance.
    // ------------------------------------------------------------------
    always_comb begin
        bus.rd_dist  = '0;
        bus.rd_label = '0;
        bus.rd_valid = 1'b0;
        for (int i = 0; i < K; i++) begin
            if ((bus.rd_sel == c_SEL_W'(i)) && r_valid[i]) begin
                bus.rd_dist  = r_dist[i];
                bus.rd_label = r_label[i];
                bus.rd_valid = 1'b1;
            end
        end
    end

    assign bus.count = r_count;
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_knn_topk.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_knn_topk
//  Description : Directed self-checking bench for knn_topk (K=4, DATA_W=16).
//                Expected values are hand-computed for both distance metrics
//                (KNN_L1_EN selects Manhattan).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_topk;
    localparam int DATA_W  = 16;
    localparam int K       = 4;
    localparam int LABEL_W = 8;

`ifdef KNN_L1_EN
    localparam longint c_B0 = 1, c_B1 = 2, c_B2 = 2, c_B3 = 7;
    localparam longint c_FIRST = 7;
    localparam longint c_EXT = 131070;
    localparam longint c_RS = 3;
    localparam longint c_L1T = 7;
`else
    localparam longint c_B0 = 1, c_B1 = 2, c_B2 = 4, c_B3 = 25;
    localparam longint c_FIRST = 25;
    localparam longint c_EXT = 64'd8589672450;
    localparam longint c_RS = 9;
    localparam longint c_L1T = 25;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    knn_topk_if #(.DATA_W(DATA_W), .K(K), .LABEL_W(LABEL_W)) bus ();

    knn_topk #(.DATA_W(DATA_W), .K(K), .LABEL_W(LABEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input int lbl, input bit last);
        bus.in_valid = 1'b1;
        bus.in_x     = 16'(x);
        bus.in_y     = 16'(y);
        bus.in_label = 8'(lbl);
        bus.in_last  = last;
        step();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_start(input int x, input int y);
        bus.start  = 1'b1;
        bus.test_x = 16'(x);
        bus.test_y = 16'(y);
        step();
        bus.start  = 1'b0;
    endtask

    task automatic chk_entry(input string tag, input int idx, input bit v,
                             input longint d, input int lbl);
        bus.rd_sel = 2'(idx);
        #1;
        chk($sformatf("%s_e%0d_valid", tag, idx), 64'(bus.rd_valid), 64'(v));
        chk($sformatf("%s_e%0d_dist", tag, idx), 64'(bus.rd_dist), 64'(d));
        chk($sformatf("%s_e%0d_label", tag, idx), 64'(bus.rd_label), 64'(lbl));
    endtask

    task automatic chk_empty(input string tag);
        for (int i = 0; i < K; i++) chk_entry(tag, i, 1'b0, 0, 0);
        chk({tag, "_count"}, 64'(bus.count), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.test_x = '0; bus.test_y = '0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0;
        bus.in_label = '0; bus.in_last = 1'b0; bus.rd_sel = '0;

        // Reset state
        step(); step();
        chk_empty("reset");
        rst = 1'b0;
        step();

        // Basic ranking
        do_start(0, 0);
        send(3, 4, 1, 1'b0);
        send(1, 1, 2, 1'b0);
        send(0, 2, 3, 1'b0);
        chk("basic_count_lat", 64'(bus.count), 64'd1);
        chk_entry("basic_lat", 0, 1'b1, c_FIRST, 1);
        send(5, 5, 4, 1'b0);
        send(-1, 0, 5, 1'b1);
        idle();
        step();
        chk("basic_done_n1", 64'(bus.done), 64'd0);
        step();
        chk("basic_done_n2", 64'(bus.done), 64'd0);
        chk_entry("basic", 0, 1'b1, c_B0, 5);
        chk_entry("basic", 1, 1'b1, c_B1, 2);
        chk_entry("basic", 2, 1'b1, c_B2, 3);
        chk_entry("basic", 3, 1'b1, c_B3, 1);
        chk("basic_count", 64'(bus.count), 64'd4);
        step();
        chk("basic_done_n3", 64'(bus.done), 64'd1);
        step();
        chk("basic_done_n4", 64'(bus.done), 64'd0);

        // Ties stay in arrival order
        do_start(0, 0);
        send(1, 0, 7, 1'b0);
        send(0, 1, 8, 1'b0);
        send(0, -1, 9, 1'b1);
        idle();
        step(); step();
        chk_entry("tie", 0, 1'b1, 1, 7);
        chk_entry("tie", 1, 1'b1, 1, 8);
        chk_entry("tie", 2, 1'b1, 1, 9);
        chk_entry("tie", 3, 1'b0, 0, 0);
        chk("tie_count", 64'(bus.count), 64'd3);
        step();
        chk("tie_done", 64'(bus.done), 64'd1);

        // Coordinate extremes
        do_start(-32768, -32768);
        send(32767, 32767, 3, 1'b1);
        idle();
        step(); step();
        chk_entry("ext", 0, 1'b1, c_EXT, 3);
        chk("ext_count", 64'(bus.count), 64'd1);
        step();
        chk("ext_done", 64'(bus.done), 64'd1);

        // Latency of a single point
        do_start(0, 0);
        send(3, -4, 6, 1'b1);
        idle();
        step();
        chk("lat_count_n1", 64'(bus.count), 64'd0);
        step();
        chk_entry("lat", 0, 1'b1, c_L1T, 6);
        chk("lat_count_n2", 64'(bus.count), 64'd1);
        step();
        chk("lat_done", 64'(bus.done), 64'd1);

        // Restart while the pipeline holds two points, with a point in the start cycle
        do_start(0, 0);
        send(1, 0, 11, 1'b0);
        send(2, 0, 12, 1'b1);
        bus.in_valid = 1'b1; bus.in_x = 16'd3; bus.in_y = 16'd0;
        bus.in_label = 8'd13; bus.in_last = 1'b0;
        do_start(10, 10);
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rs_done_%0d", i), 64'(bus.done), 64'd0);
        end
        chk_empty("rs");
        send(10, 13, 20, 1'b1);
        idle();
        step(); step();
        chk_entry("rs_new", 0, 1'b1, c_RS, 20);
        chk_entry("rs_new", 1, 1'b0, 0, 0);
        chk("rs_new_count", 64'(bus.count), 64'd1);
        step();
        chk("rs_new_done", 64'(bus.done), 64'd1);

        // Asynchronous reset mid-stream
        do_start(0, 0);
        send(1, 2, 1, 1'b0);
        send(2, 2, 2, 1'b0);
        send(3, 3, 3, 1'b1);
        chk("mid_pre_count", 64'(bus.count), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk_empty("midrst");
        idle();
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("midrst_post_done_%0d", i), 64'(bus.done), 64'd0);
        end
        chk_empty("midrst_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
